// File: rtl/ctrl_pkg.sv
// Shared control-bundle definitions for the decode control unit and the pipeline control.
package ctrl_pkg;

    localparam int CTRL_W = 15;

    // Bit positions inside the 15-bit control bundle
    localparam int CTRL_PCNOTLOAD = 14;
    localparam int CTRL_JUMP      = 13;
    localparam int CTRL_PCSRC_HI  = 12;
    localparam int CTRL_PCSRC_LO  = 11;
    localparam int CTRL_BRANCH    = 10;
    localparam int CTRL_ALUOP_HI  = 9;
    localparam int CTRL_ALUOP_LO  = 7;
    localparam int CTRL_ALUSRC    = 6;
    localparam int CTRL_MEMREAD   = 5;
    localparam int CTRL_MEMWRITE  = 4;
    localparam int CTRL_MEMTOREG  = 3;
    localparam int CTRL_REGWRITE  = 2;
    localparam int CTRL_RWSRC_HI  = 1;
    localparam int CTRL_RWSRC_LO  = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_SLT   = 3'd5,
        ALU_SHIFT = 3'd6,
        ALU_PASSB = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4  = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JAL    = 2'd2,
        PC_SRC_JALR   = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        RWS_ALU   = 2'd0,
        RWS_MEM   = 2'd1,
        RWS_PC4   = 2'd2,
        RWS_IMM   = 2'd3
    } rw_src_e;

    // True when the bundle reads data memory (the producer side of a load-use hazard)
    function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register: control bundle plus destination tag, with load enable and bubble.
module ctrl_stage_reg
    import ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              bubble,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [AW-1:0]     d_rd,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [AW-1:0]     q_rd
);

    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [AW-1:0]     rd_d, rd_q;

    // Bubble overrides the load; with neither the stage holds its contents
    always_comb begin
        ctrl_d = ctrl_q;
        rd_d   = rd_q;
        if (bubble) begin
            ctrl_d = CTRL_NOP;
            rd_d   = '0;
        end else if (en) begin
            ctrl_d = d_ctrl;
            rd_d   = d_rd;
        end
    end

    // Stage register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= CTRL_NOP;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd_q   <= rd_d;
        end
    end

    assign q_ctrl = ctrl_q;
    assign q_rd   = rd_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control: carries decoded bundles ID->EX->MEM->WB, resolves load-use stalls,
// redirect flushes and the EBREAK halt, and drives the PC / IF-ID enables.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int HALT_ON_EBREAK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_redirect,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [CTRL_W-1:0]     mem_ctrl,
    output logic [CTRL_W-1:0]     wb_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  halted
);

    localparam logic HALT_EN = (HALT_ON_EBREAK != 0);

    logic load_use, redirect, ex_bubble;
    logic ebreak_enter, halt_commit;
    logic halt_pend_d, halt_pend_q;
    logic halted_d, halted_q;

    // Hazard detection; x0 is never a real dependency, and an EBREAK in EX cannot redirect
    always_comb begin
        load_use = is_load(ex_ctrl) && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        redirect = ex_redirect && !ex_ctrl[CTRL_PCNOTLOAD];
    end

    // Priority resolution for the front-end enables and the ID->EX bubble
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        ex_bubble   = 1'b0;
        if (rst) begin
            ex_bubble = 1'b0;
        end else if (halted_q) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_bubble   = 1'b1;
        end else if (redirect) begin
            if_id_flush = 1'b1;
            ex_bubble   = 1'b1;
        end else if (halt_pend_q || load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_bubble   = 1'b1;
        end
    end

    // Halt tracking: pending once EBREAK really enters EX, committed when it is clocked into WB
    always_comb begin
        ebreak_enter = HALT_EN && !ex_bubble && id_ctrl[CTRL_PCNOTLOAD];
        halt_commit  = HALT_EN && mem_ctrl[CTRL_PCNOTLOAD];
        halted_d     = halted_q || halt_commit;
        halt_pend_d  = halt_commit ? 1'b0 : (halt_pend_q || ebreak_enter);
    end

    // Halt state flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            halt_pend_q <= halt_pend_d;
            halted_q    <= halted_d;
        end
    end

    assign halted = halted_q;

    ctrl_stage_reg #(.AW(REG_ADDR_W)) u_id_ex (
        .clk(clk), .rst(rst), .en(1'b1), .bubble(ex_bubble),
        .d_ctrl(id_ctrl), .d_rd(id_rd), .q_ctrl(ex_ctrl), .q_rd(ex_rd)
    );

    ctrl_stage_reg #(.AW(REG_ADDR_W)) u_ex_mem (
        .clk(clk), .rst(rst), .en(1'b1), .bubble(1'b0),
        .d_ctrl(ex_ctrl), .d_rd(ex_rd), .q_ctrl(mem_ctrl), .q_rd(mem_rd)
    );

    ctrl_stage_reg #(.AW(REG_ADDR_W)) u_mem_wb (
        .clk(clk), .rst(rst), .en(1'b1), .bubble(1'b0),
        .d_ctrl(mem_ctrl), .d_rd(mem_rd), .q_ctrl(wb_ctrl), .q_rd(wb_rd)
    );

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: table of single-hazard vectors plus multi-cycle sequences.
module tb_ctrl_pipe;

    logic        clk;
    logic        rst;
    logic [14:0] id_ctrl;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        ex_redirect;
    logic [14:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        pc_write, if_id_write, if_id_flush, halted;

    int total;
    int passed;

    ctrl_pipe #(.REG_ADDR_W(5), .HALT_ON_EBREAK(1)) dut (
        .clk(clk), .rst(rst),
        .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_redirect(ex_redirect),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] pre_ctrl;
        logic [4:0]  pre_rd;
        logic [14:0] ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        redir;
        logic        exp_pc;
        logic        exp_ifid;
        logic        exp_flush;
        logic [14:0] exp_ex;
        logic [4:0]  exp_exrd;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [14:0] c, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic redir);
        id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_redirect = redir;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(15'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        //         pre     prerd  id      rs1   rs2   rd    rdr   pc    ifid  fl    ex      exrd
        vecs[0] = '{15'h0024, 5'd5, 15'h0004, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0000, 5'd0};
        vecs[1] = '{15'h0024, 5'd5, 15'h0004, 5'd1, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0000, 5'd0};
        vecs[2] = '{15'h0024, 5'd0, 15'h0004, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 15'h0004, 5'd6};
        vecs[3] = '{15'h0024, 5'd6, 15'h0004, 5'd5, 5'd7, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 15'h0004, 5'd8};
        vecs[4] = '{15'h0024, 5'd5, 15'h0004, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 15'h0000, 5'd0};
        vecs[5] = '{15'h0004, 5'd5, 15'h0004, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 15'h0004, 5'd6};
        vecs[6] = '{15'h0000, 5'd0, 15'h0008, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 15'h0000, 5'd0};
        vecs[7] = '{15'h4000, 5'd0, 15'h0004, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0000, 5'd0};
        vecs[8] = '{15'h0024, 5'd5, 15'h4000, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0000, 5'd0};

        do_reset;
        drive(15'h0, 5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        chk("reset_ex_ctrl", {17'd0, ex_ctrl}, 32'h0);
        chk("reset_wb_ctrl", {17'd0, wb_ctrl}, 32'h0);
        chk("reset_pc_write", {31'd0, pc_write}, 32'h1);
        chk("reset_if_id_write", {31'd0, if_id_write}, 32'h1);
        chk("reset_halted", {31'd0, halted}, 32'h0);
        rst = 1'b1;
        #1;
        chk("in_reset_flush", {31'd0, if_id_flush}, 32'h0);

        // Table: preload EX with pre bundle, then apply the vector in ID
        for (int i = 0; i < 9; i++) begin
            do_reset;
            drive(vecs[i].pre_ctrl, 5'd0, 5'd0, vecs[i].pre_rd, 1'b0);
            @(negedge clk);
            drive(vecs[i].ctrl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].redir);
            #1;
            chk($sformatf("v%0d_pc_write", i), {31'd0, pc_write}, {31'd0, vecs[i].exp_pc});
            chk($sformatf("v%0d_if_id_write", i), {31'd0, if_id_write}, {31'd0, vecs[i].exp_ifid});
            chk($sformatf("v%0d_flush", i), {31'd0, if_id_flush}, {31'd0, vecs[i].exp_flush});
            @(negedge clk);
            chk($sformatf("v%0d_ex_ctrl", i), {17'd0, ex_ctrl}, {17'd0, vecs[i].exp_ex});
            chk($sformatf("v%0d_ex_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].exp_exrd});
        end

        // Load-use: one stall cycle, then the add enters EX
        do_reset;
        drive(15'h0024, 5'd0, 5'd0, 5'd5, 1'b0);
        @(negedge clk);
        drive(15'h0004, 5'd5, 5'd0, 5'd7, 1'b0);
        #1 chk("lu_stall_pc", {31'd0, pc_write}, 32'h0);
        @(negedge clk);
        chk("lu_bubble_ex", {17'd0, ex_ctrl}, 32'h0);
        chk("lu_release_pc", {31'd0, pc_write}, 32'h1);
        chk("lu_lw_in_mem", {17'd0, mem_ctrl}, 32'h0024);
        @(negedge clk);
        chk("lu_add_ex_ctrl", {17'd0, ex_ctrl}, 32'h0004);
        chk("lu_add_ex_rd", {27'd0, ex_rd}, 32'd7);

        // Latency of an R-type bundle through all three stages
        do_reset;
        drive(15'h0008, 5'd1, 5'd2, 5'd3, 1'b0);
        @(negedge clk);
        drive(15'h0000, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("lat_ex", {12'd0, ex_rd, ex_ctrl}, {12'd0, 5'd3, 15'h0008});
        @(negedge clk);
        chk("lat_mem", {12'd0, mem_rd, mem_ctrl}, {12'd0, 5'd3, 15'h0008});
        chk("lat_ex_empty", {17'd0, ex_ctrl}, 32'h0);
        @(negedge clk);
        chk("lat_wb", {12'd0, wb_rd, wb_ctrl}, {12'd0, 5'd3, 15'h0008});

        // EBREAK halt
        do_reset;
        drive(15'h4000, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        drive(15'h0004, 5'd0, 5'd0, 5'd1, 1'b0);
        #1;
        chk("eb_pc_hold_c1", {31'd0, pc_write}, 32'h0);
        chk("eb_halted_c1", {31'd0, halted}, 32'h0);
        @(negedge clk);
        chk("eb_halted_c2", {31'd0, halted}, 32'h0);
        chk("eb_younger_blocked", {17'd0, ex_ctrl}, 32'h0);
        @(negedge clk);
        chk("eb_halted_c3", {31'd0, halted}, 32'h1);
        chk("eb_wb_ctrl", {17'd0, wb_ctrl}, 32'h4000);
        repeat (4) @(negedge clk);
        chk("eb_halted_sticky", {31'd0, halted}, 32'h1);
        chk("eb_pc_stays_0", {31'd0, pc_write}, 32'h0);
        chk("eb_ifid_stays_0", {31'd0, if_id_write}, 32'h0);
        do_reset;
        chk("eb_rst_clears", {31'd0, halted}, 32'h0);

        // EBREAK flushed by a concurrent redirect never halts
        drive(15'h4000, 5'd0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        drive(15'h0000, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("ebr_ex_empty", {17'd0, ex_ctrl}, 32'h0);
        repeat (5) @(negedge clk);
        chk("ebr_not_halted", {31'd0, halted}, 32'h0);
        chk("ebr_pc_write", {31'd0, pc_write}, 32'h1);

        // Asynchronous reset while stalled
        do_reset;
        drive(15'h0024, 5'd0, 5'd0, 5'd5, 1'b0);
        @(negedge clk);
        drive(15'h0004, 5'd5, 5'd0, 5'd6, 1'b0);
        #1 chk("ar_stalled", {31'd0, pc_write}, 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("ar_ex_ctrl", {17'd0, ex_ctrl}, 32'h0);
        chk("ar_ex_rd", {27'd0, ex_rd}, 32'h0);
        chk("ar_pc_write", {31'd0, pc_write}, 32'h1);
        chk("ar_if_id_write", {31'd0, if_id_write}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
